one_two_sequencer: RTL and testbench

ONE_TWO_SEQUENCER -- requirements
Module: one_two_sequencer

---
 rtl/one_two_sequencer_pkg.sv | 15 +
 rtl/one_two_set.sv | 19 +
 rtl/one_two_sequencer.sv | 153 +++++++++++++++
 tb/tb_one_two_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/one_two_sequencer_pkg.sv
// Shared definitions for the one_two_sequencer sweep controller.
package one_two_sequencer_pkg;

    // Sweep FSM states. The numeric encodings are fixed.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDrive  = 2'd1,
        StSample = 2'd2,
        StDone   = 2'd3
    } state_e;

    localparam logic [2:0]  CODE_LAST     = 3'd7;
    localparam int unsigned DWELL_DEFAULT = 1;

endpackage

// File: rtl/one_two_set.sv
// Reference one_two_set: flags inputs with exactly one or exactly two bits set.
module one_two_set (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic one,
    output logic two
);

    logic [1:0] ones;

    // Population count of the three inputs.
    always_comb begin
        ones = {1'b0, a} + {1'b0, b} + {1'b0, c};
        one  = (ones == 2'd1);
        two  = (ones == 2'd2);
    end

endmodule

// File: rtl/one_two_sequencer.sv
// Sweeps all eight 3-bit codes through an external one_two_set, checks each
// response against a built-in golden model and accumulates results.
module one_two_sequencer
    import one_two_sequencer_pkg::*;
#(
    parameter int unsigned DWELL = DWELL_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       one_in,
    input  logic       two_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic [3:0] one_count,
    output logic [3:0] two_count,
    output logic [3:0] pass_count,
    output logic       fail,
    output logic [2:0] first_fail
);

    localparam logic [3:0] DwellLast = 4'(DWELL - 1);

    // Golden model: number of set bits in a code.
    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    state_e     state_q, state_d;
    logic [2:0] code_q, code_d;
    logic [3:0] dwell_q, dwell_d;
    logic [3:0] one_cnt_q, one_cnt_d;
    logic [3:0] two_cnt_q, two_cnt_d;
    logic [3:0] pass_cnt_q, pass_cnt_d;
    logic       fail_q, fail_d;
    logic [2:0] first_fail_q, first_fail_d;

    logic       exp_one;
    logic       exp_two;
    logic       match;

    // Expected response for the code currently on the bus.
    always_comb begin
        exp_one = (popcount3(code_q) == 2'd1);
        exp_two = (popcount3(code_q) == 2'd2);
        match   = (one_in == exp_one) && (two_in == exp_two);
    end

    // Next-state and datapath updates; results hold unless explicitly changed.
    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        dwell_d      = dwell_q;
        one_cnt_d    = one_cnt_q;
        two_cnt_d    = two_cnt_q;
        pass_cnt_d   = pass_cnt_q;
        fail_d       = fail_q;
        first_fail_d = first_fail_q;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d      = StDrive;
                    code_d       = 3'd0;
                    dwell_d      = 4'd0;
                    one_cnt_d    = 4'd0;
                    two_cnt_d    = 4'd0;
                    pass_cnt_d   = 4'd0;
                    fail_d       = 1'b0;
                    first_fail_d = 3'd0;
                end
            end
            StDrive: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    dwell_d = dwell_q + 4'd1;
                    if (dwell_q == DwellLast) begin
                        state_d = StSample;
                    end
                end
            end
            StSample: begin
                // An abort here drops this vector's update entirely.
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    one_cnt_d = one_cnt_q + {3'd0, one_in};
                    two_cnt_d = two_cnt_q + {3'd0, two_in};
                    if (match) begin
                        pass_cnt_d = pass_cnt_q + 4'd1;
                    end else if (!fail_q) begin
                        fail_d       = 1'b1;
                        first_fail_d = code_q;
                    end
                    if (code_q == CODE_LAST) begin
                        state_d = StDone;
                    end else begin
                        code_d  = code_q + 3'd1;
                        dwell_d = 4'd0;
                        state_d = StDrive;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            code_q       <= 3'd0;
            dwell_q      <= 4'd0;
            one_cnt_q    <= 4'd0;
            two_cnt_q    <= 4'd0;
            pass_cnt_q   <= 4'd0;
            fail_q       <= 1'b0;
            first_fail_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            dwell_q      <= dwell_d;
            one_cnt_q    <= one_cnt_d;
            two_cnt_q    <= two_cnt_d;
            pass_cnt_q   <= pass_cnt_d;
            fail_q       <= fail_d;
            first_fail_q <= first_fail_d;
        end
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        busy       = (state_q == StDrive) || (state_q == StSample);
        done       = (state_q == StDone);
        {a, b, c}  = busy ? code_q : 3'd0;
        one_count  = one_cnt_q;
        two_count  = two_cnt_q;
        pass_count = pass_cnt_q;
        fail       = fail_q;
        first_fail = first_fail_q;
    end

endmodule

// File: tb/tb_one_two_sequencer.sv
// Scoreboard bench: stimulus queues expected sweep results, monitors compare
// them whenever a done pulse appears.
module tb_one_two_sequencer;

    typedef struct {
        int one;
        int two;
        int pass;
        int fail;
        int ff;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass   = 0;
    int n_checks = 0;

    exp_t q1[$];
    exp_t q3[$];

    // DUT with DWELL=1
    logic       rst1 = 1'b1, start1 = 1'b0, abort1 = 1'b0;
    logic       one_in1, two_in1, s_one1, s_two1;
    logic       a1, b1, c1, busy1, done1, fail1;
    logic [3:0] oc1, tc1, pc1;
    logic [2:0] ff1;
    int         mode1 = 0;  // 0 normal, 1 one forced 0, 2 two forced 1

    one_two_sequencer #(.DWELL(1)) u_dut1 (
        .clk(clk), .reset(rst1), .start(start1), .abort(abort1),
        .one_in(one_in1), .two_in(two_in1),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1),
        .one_count(oc1), .two_count(tc1), .pass_count(pc1),
        .fail(fail1), .first_fail(ff1)
    );
    one_two_set u_set1 (.a(a1), .b(b1), .c(c1), .one(s_one1), .two(s_two1));
    assign one_in1 = (mode1 == 1) ? 1'b0 : s_one1;
    assign two_in1 = (mode1 == 2) ? 1'b1 : s_two1;

    // DUT with DWELL=3
    logic       rst3 = 1'b1, start3 = 1'b0, abort3 = 1'b0;
    logic       one_in3, two_in3;
    logic       a3, b3, c3, busy3, done3, fail3;
    logic [3:0] oc3, tc3, pc3;
    logic [2:0] ff3;

    one_two_sequencer #(.DWELL(3)) u_dut3 (
        .clk(clk), .reset(rst3), .start(start3), .abort(abort3),
        .one_in(one_in3), .two_in(two_in3),
        .a(a3), .b(b3), .c(c3), .busy(busy3), .done(done3),
        .one_count(oc3), .two_count(tc3), .pass_count(pc3),
        .fail(fail3), .first_fail(ff3)
    );
    one_two_set u_set3 (.a(a3), .b(b3), .c(c3), .one(one_in3), .two(two_in3));

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor for DWELL=1 instance.
    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("dut1 done without request", q1.size(), 1);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("dut1 done cycle", cyc, e.cyc);
                check("dut1 one_count", int'(oc1), e.one);
                check("dut1 two_count", int'(tc1), e.two);
                check("dut1 pass_count", int'(pc1), e.pass);
                check("dut1 fail", int'(fail1), e.fail);
                if (e.fail != 0) check("dut1 first_fail", int'(ff1), e.ff);
                check("dut1 busy in done", int'(busy1), 0);
                check("dut1 abc in done", int'({a1, b1, c1}), 0);
            end
        end
    end

    // Monitor for DWELL=3 instance.
    always @(negedge clk) begin
        if (done3 === 1'b1) begin
            if (q3.size() == 0) begin
                check("dut3 done without request", q3.size(), 1);
            end else begin
                exp_t e;
                e = q3.pop_front();
                check("dut3 done cycle", cyc, e.cyc);
                check("dut3 one_count", int'(oc3), e.one);
                check("dut3 two_count", int'(tc3), e.two);
                check("dut3 pass_count", int'(pc3), e.pass);
                check("dut3 fail", int'(fail3), e.fail);
            end
        end
    end

    // Called at a negedge; start is sampled at the next posedge (edge 0).
    task automatic sweep1(input int one, input int two, input int pass, input int fl,
                          input int ff, input bit expect_done);
        exp_t e;
        e = '{one: one, two: two, pass: pass, fail: fl, ff: ff, cyc: cyc + 1 + 8 * 2};
        if (expect_done) q1.push_back(e);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic drain1(input string name);
        int n = 0;
        while (q1.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, q1.size(), 0);
    endtask

    task automatic wait_code1(input logic [2:0] code, input string name);
        int n = 0;
        while (!(busy1 === 1'b1 && {a1, b1, c1} === code) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, int'({a1, b1, c1}), int'(code));
    endtask

    initial begin
        exp_t e;
        int n;
        repeat (2) @(negedge clk);
        rst1 = 1'b0;
        rst3 = 1'b0;
        @(negedge clk);

        // Reset state
        check("reset busy", int'(busy1), 0);
        check("reset done", int'(done1), 0);
        check("reset abc", int'({a1, b1, c1}), 0);
        check("reset counts", int'({oc1, tc1, pc1}), 0);
        check("reset fail", int'(fail1), 0);

        // Correct set in loop
        sweep1(3, 3, 8, 0, 0, 1);
        drain1("normal sweep completed");
        repeat (4) @(negedge clk);
        check("hold one_count", int'(oc1), 3);
        check("hold pass_count", int'(pc1), 8);

        // one_in stuck at 0
        mode1 = 1;
        sweep1(0, 3, 5, 1, 1, 1);
        drain1("one-forced sweep completed");

        // two_in stuck at 1
        mode1 = 2;
        sweep1(3, 8, 3, 1, 0, 1);
        drain1("two-forced sweep completed");
        mode1 = 0;

        // Abort while code 4 is driven
        sweep1(0, 0, 0, 0, 0, 0);
        wait_code1(3'd4, "reached code 4");
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        check("abort busy", int'(busy1), 0);
        check("abort pass_count", int'(pc1), 4);
        check("abort one_count", int'(oc1), 2);
        check("abort two_count", int'(tc1), 1);
        repeat (3) @(negedge clk);
        check("abort held pass_count", int'(pc1), 4);
        sweep1(3, 3, 8, 0, 0, 1);
        @(negedge clk);
        check("restart cleared pass_count", int'(pc1), 0);
        drain1("post-abort sweep completed");

        // start+abort together in IDLE
        start1 = 1'b1;
        abort1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        abort1 = 1'b0;
        check("start+abort stays idle", int'(busy1), 0);

        // start re-pulsed mid sweep; timing must be unchanged
        sweep1(3, 3, 8, 0, 0, 1);
        repeat (3) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (6) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (done1 !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done reached", int'(done1), 1);
        // start and abort during DONE: no effect
        start1 = 1'b1;
        abort1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        abort1 = 1'b0;
        check("idle after done", int'(busy1), 0);
        check("done is one cycle", int'(done1), 0);
        repeat (3) @(negedge clk);
        check("start in done not queued", int'(busy1), 0);
        check("results kept after done", int'(pc1), 8);

        // DWELL=3: reset during code 5
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        n = 0;
        while (!(busy3 === 1'b1 && {a3, b3, c3} === 3'd5) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("dut3 reached code 5", int'({a3, b3, c3}), 5);
        rst3 = 1'b1;
        start3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        start3 = 1'b0;
        check("midreset busy", int'(busy3), 0);
        check("midreset abc", int'({a3, b3, c3}), 0);
        check("midreset counts", int'({oc3, tc3, pc3}), 0);
        check("midreset fail", int'({fail3, ff3}), 0);
        check("midreset done", int'(done3), 0);

        // DWELL=3 full sweep: done at edge 32
        e = '{one: 3, two: 3, pass: 8, fail: 0, ff: 0, cyc: cyc + 1 + 8 * 4};
        q3.push_back(e);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        n = 0;
        while (q3.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("dut3 sweep completed", q3.size(), 0);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
